rr_packet_arbiter: RTL

Round-robin arbiter that grants one of Count packet-oriented requesters access to a single output stream. It produces the one-hot-or-zero select that drives the team's onehot_mux data path, and holds that select for a whole packet, from first beat to last beat. It sits upstream of any shared consumer, for example a bus master port or a FIFO write side.

---
 rtl/timewave_arb_pkg.sv | 9 +
 rtl/onehot_mux.sv | 18 +
 rtl/rr_pick_onehot.sv | 20 ++
 rtl/rr_packet_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/timewave_arb_pkg.sv
// rtl/timewave_arb_pkg.sv - shared types for the packet arbiter
package timewave_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

endpackage

// File: rtl/onehot_mux.sv
// rtl/onehot_mux.sv - AND-OR mux driven by a onehot-or-zero select
module onehot_mux #(
   parameter int Count = 3,
   parameter int Width = 8
) (
   input  logic [Count-1:0] sel,
   input  logic [Width-1:0] data [Count],
   output logic [Width-1:0] out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < Count; i++) begin
         out = out | (data[i] & {Width{sel[i]}});
      end
   end

endmodule

// File: rtl/rr_pick_onehot.sv
// rtl/rr_pick_onehot.sv - round-robin winner pick, onehot-or-zero result
module rr_pick_onehot #(
   parameter int Count = 3
) (
   input  logic [Count-1:0]         req,
   input  logic [$clog2(Count)-1:0] ptr,
   output logic [Count-1:0]         winner
);

   logic [Count-1:0] rotated;
   logic [Count-1:0] rot_oh;
   logic [Count-1:0] rot_hi_unused;
   logic [Count-1:0] win_lo_unused;

   // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
   assign {rot_hi_unused, rotated} = {req, req} >> ptr;
   assign rot_oh = rotated & (~rotated + {{(Count-1){1'b0}}, 1'b1});
   assign {winner, win_lo_unused} = {rot_oh, rot_oh} << ptr;

endmodule

// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - round-robin arbiter holding grant for a whole packet
module rr_packet_arbiter
   import timewave_arb_pkg::*;
#(
   parameter int Count = 3,
   parameter int Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Count-1:0] req_valid_i,
   output logic [Count-1:0] req_ready_o,
   input  logic [Width-1:0] req_words_i [Count],
   input  logic [Count-1:0] req_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_word_o,
   output logic             out_last_o,
   output logic [Count-1:0] grant_o
);

   localparam int PtrW = $clog2(Count);

   arb_state_e       state_q, state_n;
   logic [Count-1:0] grant_q, grant_n, winner;
   logic [PtrW-1:0]  ptr_q, ptr_n, g_idx;
   logic [Width-1:0] sel_word;
   logic [0:0]       sel_last;
   logic [0:0]       last_arr [Count];

   assign grant_o = grant_q;

   rr_pick_onehot #(.Count(Count)) u_pick (
      .req    (req_valid_i),
      .ptr    (ptr_q),
      .winner (winner)
   );

   always_comb begin
      for (int i = 0; i < Count; i++) begin
         last_arr[i] = req_last_i[i];
      end
   end

   onehot_mux #(.Count(Count), .Width(Width)) u_word_mux (
      .sel  (grant_q),
      .data (req_words_i),
      .out  (sel_word)
   );

   onehot_mux #(.Count(Count), .Width(1)) u_last_mux (
      .sel  (grant_q),
      .data (last_arr),
      .out  (sel_last)
   );

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < Count; i++) begin
         if (grant_q[i]) g_idx = PtrW'(i);
      end
   end

   always_comb begin
      state_n     = state_q;
      grant_n     = grant_q;
      ptr_n       = ptr_q;
      out_valid_o = 1'b0;
      req_ready_o = '0;
      out_word_o  = '0;
      out_last_o  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|req_valid_i) begin
               grant_n = winner;
               state_n = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            // Valid comes only from the granted requester, never from out_ready_i.
            out_valid_o = (|(req_valid_i & grant_q)) && !rst_i;
            req_ready_o = rst_i ? '0 : (grant_q & {Count{out_ready_i}});
            out_word_o  = sel_word;
            out_last_o  = sel_last[0];
            if (out_valid_o && out_ready_i && out_last_o) begin
               state_n = ARB_IDLE;
               grant_n = '0;
               ptr_n   = (g_idx == PtrW'(Count - 1)) ? '0 : g_idx + PtrW'(1);
            end
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         ptr_q   <= ptr_n;
      end
   end

endmodule
